// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the instruction/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } arb_state_t;

  typedef enum logic {
    GNT_I,
    GNT_D
  } arb_grant_t;

  // Width of a counter that must hold values 0..limit inclusive.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return unsigned'($clog2(limit + 1));
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one memory req/ack port between fetch and data stages; data has priority,
// and a starvation counter forces a fetch grant after WAIT_LIMIT data grants.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned WAIT_LIMIT = 4
) (
  input  logic                    i_Clock,
  input  logic                    i_Reset,
  input  logic                    i_IReq,
  input  logic [ADDR_WIDTH-1:0]   i_IAddr,
  output logic [DATA_WIDTH-1:0]   o_IRdData,
  output logic                    o_IAck,
  input  logic                    i_DReq,
  input  logic                    i_DWe,
  input  logic [ADDR_WIDTH-1:0]   i_DAddr,
  input  logic [DATA_WIDTH/8-1:0] i_DBe,
  input  logic [DATA_WIDTH-1:0]   i_DWrData,
  output logic [DATA_WIDTH-1:0]   o_DRdData,
  output logic                    o_DAck,
  output logic                    o_MemReq,
  output logic                    o_MemWe,
  output logic [ADDR_WIDTH-1:0]   o_MemAddr,
  output logic [DATA_WIDTH/8-1:0] o_MemBe,
  output logic [DATA_WIDTH-1:0]   o_MemWrData,
  input  logic [DATA_WIDTH-1:0]   i_MemRdData,
  input  logic                    i_MemAck,
  output logic                    o_Busy
);

  localparam int unsigned BeWidth  = DATA_WIDTH / 8;
  localparam int unsigned CntWidth = cnt_width(WAIT_LIMIT);
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(WAIT_LIMIT);

  arb_state_t            state_q, state_d;
  arb_grant_t            grant_q, grant_d;
  logic [CntWidth-1:0]   starve_q, starve_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [BeWidth-1:0]    mem_be_q, mem_be_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] irdata_q, irdata_d;
  logic [DATA_WIDTH-1:0] drdata_q, drdata_d;
  logic                  iack_q, iack_d;
  logic                  dack_q, dack_d;
  logic                  busy_q, busy_d;
  logic                  i_wins;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    starve_d    = starve_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    irdata_d    = irdata_q;
    drdata_d    = drdata_q;
    iack_d      = 1'b0;
    dack_d      = 1'b0;
    i_wins      = i_IReq && (!i_DReq || (starve_q == CntMax));

    unique case (state_q)
      IDLE: begin
        if (i_IReq || i_DReq) begin
          state_d   = ACCESS;
          mem_req_d = 1'b1;
          if (i_wins) begin
            grant_d     = GNT_I;
            starve_d    = '0;
            mem_we_d    = 1'b0;
            mem_addr_d  = i_IAddr;
            mem_be_d    = '1;
            mem_wdata_d = '0;
          end else begin
            grant_d     = GNT_D;
            // Only data grants that make a pending fetch wait count toward starvation.
            if (i_IReq && (starve_q != CntMax)) starve_d = starve_q + 1'b1;
            mem_we_d    = i_DWe;
            mem_addr_d  = i_DAddr;
            mem_be_d    = i_DBe;
            mem_wdata_d = i_DWrData;
          end
        end
      end
      ACCESS: begin
        if (i_MemAck) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          if (grant_q == GNT_I) begin
            irdata_d = i_MemRdData;
            iack_d   = 1'b1;
          end else begin
            drdata_d = i_MemRdData;
            dack_d   = 1'b1;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q     <= IDLE;
      grant_q     <= GNT_I;
      starve_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      irdata_q    <= '0;
      drdata_q    <= '0;
      iack_q      <= 1'b0;
      dack_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      starve_q    <= starve_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      irdata_q    <= irdata_d;
      drdata_q    <= drdata_d;
      iack_q      <= iack_d;
      dack_q      <= dack_d;
      busy_q      <= busy_d;
    end
  end

  assign o_MemReq    = mem_req_q;
  assign o_MemWe     = mem_we_q;
  assign o_MemAddr   = mem_addr_q;
  assign o_MemBe     = mem_be_q;
  assign o_MemWrData = mem_wdata_q;
  assign o_IRdData   = irdata_q;
  assign o_DRdData   = drdata_q;
  assign o_IAck      = iack_q;
  assign o_DAck      = dack_q;
  assign o_Busy      = busy_q;

endmodule
